// File: rtl/traffic_light_ctrl_pkg.sv
// Shared encodings for the traffic light controller:
// phase states, lamp one-hot codes and walk-exit direction.
package traffic_pkg;

   typedef enum logic [2:0] {
      NSG  = 3'd0,
      NSY  = 3'd1,
      AR1  = 3'd2,
      EWG  = 3'd3,
      EWY  = 3'd4,
      AR2  = 3'd5,
      WALK = 3'd6
   } phase_e;

   // lamp one-hot is {red, yellow, green}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor/button inputs and lamp/status outputs of the
// traffic light controller.
interface traffic_light_ctrl_if;
   import traffic_pkg::*;

   logic       ns_car;
   logic       ew_car;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   phase_e     phase;
   logic       ped_pending;

   modport master (
      output ns_car, ew_car, ped_req,
      input  ns_light, ew_light, walk, phase, ped_pending
   );

   modport slave (
      input  ns_car, ew_car, ped_req,
      output ns_light, ew_light, walk, phase, ped_pending
   );

endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Per-phase cycle counter: clears on a phase change,
// otherwise counts up and saturates instead of wrapping.
module phase_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   output logic [W-1:0] t
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t <= '0;
      end else if (clear) begin
         t <= '0;
      end else if (t != {W{1'b1}}) begin
         t <= t + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with pedestrian phase;
// Moore FSM, lamps registered from the next-state decode.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int T_GREEN    = 20,
   parameter int T_MAXGREEN = 60,
   parameter int T_YELLOW   = 5,
   parameter int T_ALLRED   = 2,
   parameter int T_WALK     = 10
) (
   input  logic                clk,
   input  logic                reset,
   traffic_light_ctrl_if.slave bus
);

   localparam int TMAX = max2(max2(max2(T_GREEN, T_MAXGREEN),
                                   max2(T_YELLOW, T_ALLRED)), T_WALK);
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [TW-1:0] END_MIN = TW'(T_GREEN - 1);
   localparam logic [TW-1:0] END_MAX = TW'(T_MAXGREEN - 1);
   localparam logic [TW-1:0] END_YEL = TW'(T_YELLOW - 1);
   localparam logic [TW-1:0] END_AR  = TW'(T_ALLRED - 1);
   localparam logic [TW-1:0] END_WLK = TW'(T_WALK - 1);

   phase_e        state_reg;
   phase_e        state_next;
   dir_e          next_dir;
   logic          ped_pending;
   logic [TW-1:0] t;
   logic          clr;

   assign clr = (state_next != state_reg);

   phase_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (clr),
      .t     (t)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         NSG: if ((t >= END_MIN && (bus.ew_car || ped_pending))
                  || t >= END_MAX)
                 state_next = NSY;
         NSY: if (t >= END_YEL) state_next = AR1;
         AR1: if (t >= END_AR)
                 state_next = ped_pending ? WALK : EWG;
         EWG: if ((t >= END_MIN && (bus.ns_car || ped_pending))
                  || t >= END_MAX)
                 state_next = EWY;
         EWY: if (t >= END_YEL) state_next = AR2;
         AR2: if (t >= END_AR)
                 state_next = ped_pending ? WALK : NSG;
         WALK: if (t >= END_WLK)
                 state_next = (next_dir == DIR_EW) ? EWG : NSG;
         default: state_next = AR2;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= AR2;
         next_dir     <= DIR_NS;
         ped_pending  <= 1'b0;
         bus.ns_light <= LAMP_RED;
         bus.ew_light <= LAMP_RED;
         bus.walk     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (clr && state_reg == AR1) next_dir <= DIR_EW;
         else if (clr && state_reg == AR2) next_dir <= DIR_NS;
         // entering WALK serves the request, even one raised this cycle
         if (clr && state_next == WALK) ped_pending <= 1'b0;
         else if (bus.ped_req && state_reg != WALK) ped_pending <= 1'b1;
         bus.ns_light <= LAMP_RED;
         bus.ew_light <= LAMP_RED;
         bus.walk     <= 1'b0;
         case (state_next)
            NSG:     bus.ns_light <= LAMP_GRN;
            NSY:     bus.ns_light <= LAMP_YEL;
            EWG:     bus.ew_light <= LAMP_GRN;
            EWY:     bus.ew_light <= LAMP_YEL;
            WALK:    bus.walk     <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.phase       = state_reg;
   assign bus.ped_pending = ped_pending;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl with short timings:
// driver queues expected phase/pending per edge, monitor checks.
module tb_traffic_light_ctrl;
   import traffic_pkg::*;

   typedef struct packed {
      phase_e ph;
      logic   pp;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sbq[$];
   exp_t e;
   logic conflict;

   traffic_light_ctrl_if tif();

   traffic_light_ctrl #(
      .T_GREEN    (4),
      .T_MAXGREEN (8),
      .T_YELLOW   (2),
      .T_ALLRED   (1),
      .T_WALK     (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] lamp_ns(input phase_e p);
      case (p)
         NSG:     return 3'b001;
         NSY:     return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] lamp_ew(input phase_e p);
      case (p)
         EWG:     return 3'b001;
         EWY:     return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t",
                  name, act, req, $time);
      end
   endtask

   // monitor: one queued expectation per rising edge
   initial begin
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("phase", 8'(tif.phase), 8'(e.ph));
            chk("ns_light", 8'(tif.ns_light), 8'(lamp_ns(e.ph)));
            chk("ew_light", 8'(tif.ew_light), 8'(lamp_ew(e.ph)));
            chk("walk", 8'(tif.walk), 8'(e.ph == WALK));
            chk("ped_pending", 8'(tif.ped_pending), 8'(e.pp));
            conflict = (tif.ns_light[0] && tif.ew_light[0]) ||
                       ((tif.ns_light[0] || tif.ew_light[0]) && tif.walk);
            chk("no_conflict", 8'(conflict), 8'd0);
         end
      end
   end

   task automatic step(input logic ns, input logic ew, input logic ped,
                       input phase_e ph, input logic pp);
      tif.ns_car  = ns;
      tif.ew_car  = ew;
      tif.ped_req = ped;
      @(posedge clk);
      sbq.push_back('{ph, pp});
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic ns, input logic ew,
                      input logic ped, input phase_e ph, input logic pp);
      for (int i = 0; i < n; i++) step(ns, ew, ped, ph, pp);
   endtask

   // reset lands mid-cycle, so AR2/red must show before any edge
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("async_phase", 8'(tif.phase), 8'(AR2));
      chk("async_ns_red", 8'(tif.ns_light), 8'b100);
      chk("async_ew_red", 8'(tif.ew_light), 8'b100);
      chk("async_walk", 8'(tif.walk), 8'd0);
      @(posedge clk);
      sbq.push_back('{AR2, 1'b0});
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      tif.ns_car  = 1'b0;
      tif.ew_car  = 1'b0;
      tif.ped_req = 1'b0;
      @(negedge clk);
      #1;
      do_reset();
      // EW demand: NSG 4, NSY 2, AR1 1
      run(4, 0, 1, 0, NSG, 0);
      run(2, 0, 1, 0, NSY, 0);
      step(0, 1, 0, AR1, 0);
      // EWG without NS demand ends on max green
      run(8, 0, 1, 0, EWG, 0);
      run(2, 0, 0, 0, EWY, 0);
      step(0, 0, 0, AR2, 0);
      // pedestrian from NSG, press on AR1 exit and in WALK
      step(0, 0, 1, NSG, 1);
      run(3, 0, 0, 0, NSG, 1);
      run(2, 0, 0, 0, NSY, 1);
      step(0, 0, 0, AR1, 1);
      step(0, 0, 1, WALK, 0);
      step(0, 0, 1, WALK, 0);
      step(0, 0, 0, WALK, 0);
      // WALK returns to EW; NS demand, ped pressed in EWY
      step(1, 0, 0, EWG, 0);
      run(3, 1, 0, 0, EWG, 0);
      step(1, 0, 1, EWY, 1);
      step(1, 0, 0, EWY, 1);
      step(1, 0, 0, AR2, 1);
      run(3, 0, 0, 0, WALK, 0);
      step(0, 1, 0, NSG, 0);
      run(3, 0, 1, 0, NSG, 0);
      step(0, 1, 0, NSY, 0);
      // abort in yellow, then idle NSG up to max green
      do_reset();
      step(0, 0, 0, NSG, 0);
      run(7, 0, 0, 0, NSG, 0);
      step(0, 0, 0, NSY, 0);
      repeat (2) @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
